// File: rtl/lsu_pkg.sv
// Shared funct3 codes and FSM state encoding for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;
endpackage

// File: rtl/lsu_byte_lane.sv
// Lane extraction with sign/zero extension for loads, and lane merge for
// sub-word stores into an existing memory word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh   = {byte_off, 3'b000};
  assign half_sh   = {byte_off[1], 4'b0000};
  assign shifted   = rd_word >> byte_sh;
  assign byte_val  = shifted[7:0];
  assign half_val  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'h0, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'h0, half_val};
      F3_W:    load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merge_data = rd_word;
    case (funct3)
      F3_B:    merge_data = (rd_word & ~byte_mask) | (({24'h0, wdata[7:0]} << byte_sh) & byte_mask);
      F3_H:    merge_data = (rd_word & ~half_mask) | (({16'h0, wdata} << half_sh) & half_mask);
      default: merge_data = rd_word;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: combinational loads, single-cycle SW, and a
// two-cycle read-modify-write for SB/SH against a word-write-only memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        access_fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [31:0] word_addr;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        f3_legal;
  logic        range_bad;
  logic        align_bad;
  logic        active;
  logic        ok_req;

  assign word_addr = {{(30-AW){1'b0}}, addr[AW+1:2], 2'b00};
  assign range_bad = {1'b0, addr} >= BYTE_LIMIT;

  always_comb begin
    f3_legal  = 1'b0;
    align_bad = 1'b0;
    case (funct3)
      F3_B:  f3_legal = 1'b1;
      F3_H:  begin f3_legal = 1'b1;     align_bad = addr[0];          end
      F3_W:  begin f3_legal = 1'b1;     align_bad = (addr[1:0] != 2'b00); end
      F3_BU: f3_legal = !req_we;
      F3_HU: begin f3_legal = !req_we;  align_bad = addr[0];          end
      default: f3_legal = 1'b0;
    endcase
  end

  // Errors are only reported for a fresh request; the RMW_WR cycle ignores inputs.
  assign active       = rst && (state_q == IDLE) && req_valid;
  assign access_fault = active && (!f3_legal || range_bad);
  assign misaligned   = active && !access_fault && align_bad;
  assign ok_req       = active && !access_fault && !align_bad;

  lsu_byte_lane u_lane (
    .funct3     (funct3),
    .byte_off   (addr[1:0]),
    .rd_word    (mem_RD),
    .wdata      (wdata[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    rdata   = 32'h0;
    stall   = 1'b0;
    mem_A   = 32'h0;
    mem_WD  = 32'h0;
    mem_WE  = 1'b0;
    state_d = state_q;
    merge_d = merge_q;
    addr_d  = addr_q;
    if (rst && state_q == RMW_WR) begin
      mem_A   = {{(30-AW){1'b0}}, addr_q, 2'b00};
      mem_WD  = merge_q;
      mem_WE  = 1'b1;
      state_d = IDLE;
    end else if (ok_req) begin
      mem_A = word_addr;
      if (!req_we) begin
        rdata = load_data;
      end else if (funct3 == F3_W) begin
        mem_WD = wdata;
        mem_WE = 1'b1;
      end else begin
        stall   = 1'b1;
        state_d = RMW_WR;
        merge_d = merge_data;
        addr_d  = addr[AW+1:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      merge_q <= 32'h0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        access_fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] tb_mem [0:1023];
  logic        bk_we;
  logic [9:0]  bk_idx;
  logic [31:0] bk_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024), .AW(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_WE       (mem_WE),
    .mem_RD       (mem_RD)
  );

  assign mem_RD = tb_mem[mem_A[11:2]];

  always @(posedge clk) begin
    if (mem_WE) tb_mem[mem_A[11:2]] <= mem_WD;
    else if (bk_we) tb_mem[bk_idx] <= bk_data;
  end

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = d;
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b0; bk_we = 1'b1; bk_idx = idx; bk_data = data;
    @(posedge clk);
    #1 bk_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0004, 32'h1234_5678);
    total++;
    if ({rdata, stall, misaligned, access_fault, mem_A, mem_WD, mem_WE} !== 100'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rdata=%h stall=%b mis=%b af=%b A=%h WD=%h WE=%b want all 0",
               rdata, stall, misaligned, access_fault, mem_A, mem_WD, mem_WE);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 1'b0, 3'b010, 32'h0000_0004, 32'h0);
    total++;
    if ({rdata, stall, mem_A, mem_WE} !== 66'h0) begin
      bad++;
      $display("FAIL idle_outputs: got rdata=%h stall=%b A=%h WE=%b want 0", rdata, stall, mem_A, mem_WE);
    end
    $display("reset/idle checked");
  endtask

  task automatic check_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    total++;
    if (rdata !== exp || stall !== 1'b0 || mem_WE !== 1'b0) begin
      bad++;
      $display("FAIL %s: got rdata=%h stall=%b WE=%b want rdata=%h stall=0 WE=0", name, rdata, stall, mem_WE, exp);
    end else $display("load %s addr=%h rdata=%h", name, a, rdata);
  endtask

  task automatic test_loads;
    preload(10'd1, 32'h8000_0020);
    check_load("lb_4",  3'b000, 32'h4, 32'h0000_0020);
    check_load("lb_7",  3'b000, 32'h7, 32'hFFFF_FF80);
    check_load("lbu_7", 3'b100, 32'h7, 32'h0000_0080);
    check_load("lh_6",  3'b001, 32'h6, 32'hFFFF_8000);
    check_load("lhu_6", 3'b101, 32'h6, 32'h0000_8000);
    check_load("lw_4",  3'b010, 32'h4, 32'h8000_0020);
  endtask

  task automatic rmw_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_a, input logic [31:0] exp_wd);
    drive(1'b1, 1'b1, f3, a, d);
    total++;
    if (stall !== 1'b1 || mem_WE !== 1'b0 || mem_A !== exp_a) begin
      bad++;
      $display("FAIL %s_read: got stall=%b WE=%b A=%h want stall=1 WE=0 A=%h", name, stall, mem_WE, mem_A, exp_a);
    end
    @(negedge clk); #1;
    total++;
    if (stall !== 1'b0 || mem_WE !== 1'b1 || mem_A !== exp_a || mem_WD !== exp_wd) begin
      bad++;
      $display("FAIL %s_write: got stall=%b WE=%b A=%h WD=%h want stall=0 WE=1 A=%h WD=%h",
               name, stall, mem_WE, mem_A, mem_WD, exp_a, exp_wd);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    total++;
    if (tb_mem[exp_a[11:2]] !== exp_wd) begin
      bad++;
      $display("FAIL %s_mem: got %h want %h", name, tb_mem[exp_a[11:2]], exp_wd);
    end else $display("store %s addr=%h mem=%h", name, a, exp_wd);
  endtask

  task automatic test_sub_word_store;
    preload(10'd2, 32'h1122_3344);
    rmw_store("sb_9", 3'b000, 32'h9, 32'h0000_00AB, 32'h8, 32'h1122_AB44);
    rmw_store("sh_a", 3'b001, 32'hA, 32'hFFFF_BEEF, 32'h8, 32'hBEEF_AB44);
  endtask

  task automatic test_sw;
    drive(1'b1, 1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF);
    total++;
    if (mem_WE !== 1'b1 || stall !== 1'b0 || mem_A !== 32'hC || mem_WD !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL sw_c: got WE=%b stall=%b A=%h WD=%h want WE=1 stall=0 A=0000000c WD=deadbeef",
               mem_WE, stall, mem_A, mem_WD);
    end else $display("store sw_c addr=0000000c");
    check_load("lw_c", 3'b010, 32'hC, 32'hDEAD_BEEF);
  endtask

  task automatic test_misaligned;
    preload(10'd0, 32'h55AA_55AA);
    drive(1'b1, 1'b0, 3'b001, 32'h5, 32'h0);
    total++;
    if (misaligned !== 1'b1 || access_fault !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL lh_5_mis: got mis=%b af=%b rdata=%h want mis=1 af=0 rdata=0", misaligned, access_fault, rdata);
    end
    drive(1'b1, 1'b1, 3'b010, 32'h2, 32'hCAFE_F00D);
    total++;
    if (misaligned !== 1'b1 || mem_WE !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL sw_2_mis: got mis=%b WE=%b stall=%b want mis=1 WE=0 stall=0", misaligned, mem_WE, stall);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    total++;
    if (tb_mem[0] !== 32'h55AA_55AA) begin
      bad++;
      $display("FAIL sw_2_mem: got %h want 55aa55aa", tb_mem[0]);
    end
    $display("misaligned cases checked");
  endtask

  task automatic check_fault(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic exp_af);
    drive(1'b1, we, f3, a, 32'h1111_1111);
    total++;
    if (access_fault !== exp_af || misaligned !== 1'b0 || (exp_af && (mem_WE !== 1'b0 || rdata !== 32'h0))) begin
      bad++;
      $display("FAIL %s: got af=%b mis=%b WE=%b rdata=%h want af=%b mis=0", name, access_fault, misaligned,
               mem_WE, rdata, exp_af);
    end else $display("fault %s af=%b", name, access_fault);
  endtask

  task automatic test_faults;
    preload(10'd1023, 32'h0123_4567);
    check_fault("lw_1000",  1'b0, 3'b010, 32'h0000_1000, 1'b1);
    check_fault("f3_011",   1'b0, 3'b011, 32'h0000_0004, 1'b1);
    check_fault("lw_1001",  1'b0, 3'b010, 32'h0000_1001, 1'b1);
    check_fault("sbu_4",    1'b1, 3'b100, 32'h0000_0004, 1'b1);
    check_fault("lw_high",  1'b0, 3'b010, 32'h8000_0000, 1'b1);
    check_load("lw_ffc", 3'b010, 32'h0000_0FFC, 32'h0123_4567);
  endtask

  task automatic test_reset_during_rmw;
    preload(10'd4, 32'h0A0B_0C0D);
    drive(1'b1, 1'b1, 3'b001, 32'h10, 32'h0000_1234);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL sh_10_stall: got stall=%b want 1", stall);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (mem_WE !== 1'b0) begin
      bad++;
      $display("FAIL sh_10_gated: got WE=%b want 0", mem_WE);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    total++;
    if (tb_mem[4] !== 32'h0A0B_0C0D) begin
      bad++;
      $display("FAIL sh_10_dropped: got %h want 0a0b0c0d", tb_mem[4]);
    end else $display("store sh_10 dropped by reset");
    rmw_store("sh_12", 3'b001, 32'h12, 32'h0000_5678, 32'h10, 32'h5678_0C0D);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    bk_we = 1'b0; bk_idx = 10'd0; bk_data = 32'h0;
    test_reset;
    test_loads;
    test_sub_word_store;
    test_sw;
    test_misaligned;
    test_faults;
    test_reset_during_rmw;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
